// File: rtl/register_file.sv
// register_file
//   Architectural integer register file: 32 x 64-bit (X0..X31), two
//   combinational read ports and one synchronous write port. X31 is the
//   zero register (XZR) and has no storage. X20 is exported continuously
//   for debug observation.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   -> a write in flight is forwarded to a read port addressing
//                  the same register, in the same cycle, before the edge.
//     undefined -> read ports return stored contents only.
//
// Ports
//   clk        in   1   write clock (rising edge)
//   Reset      in   1   asynchronous active-low reset, clears all registers
//   ReadReg1   in   5   read port 1 index
//   ReadReg2   in   5   read port 2 index
//   WriteReg   in   5   write port index
//   WriteData  in  64   write data
//   RegWrite   in   1   write enable, active high
//   ReadData1  out 64   contents of ReadReg1 (0 for index 31)
//   ReadData2  out 64   contents of ReadReg2 (0 for index 31)
//   X20        out 64   stored contents of register 20 (never bypassed)

module register_file (
  input  logic        clk,
  input  logic        Reset,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  input  logic [4:0]  WriteReg,
  input  logic [63:0] WriteData,
  input  logic        RegWrite,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2,
  output logic [63:0] X20
);

  localparam logic [4:0] XZR = 5'd31;

  // Only X0..X30 are physical; index 31 never reaches the array.
  logic [63:0] regs [0:30];

  logic write_ok;
  assign write_ok = RegWrite && (WriteReg != XZR);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 31; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[WriteReg] <= WriteData;
    end
  end

  logic [63:0] stored1;
  logic [63:0] stored2;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (ReadReg1 != XZR) stored1 = regs[ReadReg1];
    if (ReadReg2 != XZR) stored2 = regs[ReadReg2];
  end

`ifdef RF_BYPASS_EN
  // Forwarding is gated by Reset so every output reads 0 during reset.
  logic fwd1;
  logic fwd2;
  assign fwd1 = Reset && write_ok && (WriteReg == ReadReg1);
  assign fwd2 = Reset && write_ok && (WriteReg == ReadReg2);
  assign ReadData1 = fwd1 ? WriteData : stored1;
  assign ReadData2 = fwd2 ? WriteData : stored2;
`else
  assign ReadData1 = stored1;
  assign ReadData2 = stored2;
`endif

  assign X20 = regs[20];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        Reset;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [63:0] X20;

  register_file dut (
    .clk       (clk),
    .Reset     (Reset),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .X20       (X20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;   // 0: ReadData1, 1: ReadData2, 2: X20
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mdl [0:31];
  int          vectors;
  int          miscompares;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [63:0] model_read(input logic [4:0] idx);
    logic [63:0] v;
    if (!Reset || idx == 5'd31) v = '0;
    else if (BYPASS && RegWrite && WriteReg != 5'd31 && WriteReg == idx) v = WriteData;
    else v = mdl[idx];
    return v;
  endfunction

  task automatic push_exp(input string tag, input int port, input logic [63:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Drive both read indices, queue the model's expectations, let the
  // combinational paths settle, then drain the scoreboard against the DUT.
  task automatic check_reads(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    exp_t        e;
    logic [63:0] obs;
    ReadReg1 = r1;
    ReadReg2 = r2;
    push_exp({tag, "_rd1"}, 0, model_read(r1));
    push_exp({tag, "_rd2"}, 1, model_read(r2));
    push_exp({tag, "_x20"}, 2, Reset ? mdl[20] : 64'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        0:       obs = ReadData1;
        1:       obs = ReadData2;
        default: obs = X20;
      endcase
      vectors++;
      assert (obs === e.exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Called at a negedge; applies one write cycle and returns at the next negedge.
  task automatic do_write(input logic [4:0] idx, input logic [63:0] data, input logic en);
    WriteReg  = idx;
    WriteData = data;
    RegWrite  = en;
    @(posedge clk);
    if (Reset && en && idx != 5'd31) mdl[idx] = data;
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    Reset     = 1'b0;
    ReadReg1  = 5'd0;
    ReadReg2  = 5'd0;
    WriteReg  = 5'd0;
    WriteData = '0;
    RegWrite  = 1'b0;

    // Reset held: a write attempt is blocked, outputs stay 0.
    @(negedge clk);
    do_write(5'd1, 64'h00000000_000000FF, 1'b1);
    check_reads("reset", 5'd1, 5'd2);

    // Release reset; first write lands on the first edge.
    Reset = 1'b1;
    do_write(5'd3, 64'd4, 1'b1);
    check_reads("wr3", 5'd3, 5'd2);

    // Zero register.
    do_write(5'd31, 64'h00000000_DEADBEEF, 1'b1);
    check_reads("xzr", 5'd31, 5'd31);

    // X20 observation port, and a disabled write that must not change it.
    do_write(5'd20, 64'h01234567_89ABCDEF, 1'b1);
    check_reads("x20_wr", 5'd20, 5'd3);
    do_write(5'd20, 64'hFFFF0000_FFFF0000, 1'b0);
    check_reads("x20_noen", 5'd20, 5'd20);

    // Same-cycle read of a register being written (bypass-dependent).
    WriteReg  = 5'd5;
    WriteData = 64'd9;
    RegWrite  = 1'b1;
    check_reads("byp_pre", 5'd5, 5'd3);
    @(posedge clk);
    mdl[5] = 64'd9;
    @(negedge clk);
    RegWrite = 1'b0;
    check_reads("byp_post", 5'd5, 5'd5);

    // A pending write to 31 never forwards.
    WriteReg  = 5'd31;
    WriteData = 64'hAAAA_BBBB_CCCC_DDDD;
    RegWrite  = 1'b1;
    check_reads("byp_xzr", 5'd31, 5'd5);
    @(negedge clk);
    RegWrite = 1'b0;

    // Random write/readback traffic, including disabled writes.
    for (int k = 0; k < 12; k++) begin
      logic [4:0]  idx;
      logic [63:0] data;
      idx  = 5'($urandom_range(0, 31));
      data = {$urandom(), $urandom()};
      do_write(idx, data, (k % 4) != 3);
      check_reads($sformatf("rnd%0d", k), idx, 5'($urandom_range(0, 31)));
    end

    // Ensure X3 holds 4, then assert reset between edges.
    do_write(5'd3, 64'd4, 1'b1);
    check_reads("pre_arst", 5'd3, 5'd20);
    #2;
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    check_reads("arst", 5'd3, 5'd20);

    // Write presented while reset is low: no forwarding, no storage.
    WriteReg  = 5'd5;
    WriteData = 64'h5555_5555_5555_5555;
    RegWrite  = 1'b1;
    check_reads("rst_byp", 5'd5, 5'd5);
    @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    Reset    = 1'b1;
    check_reads("rst_nowr", 5'd5, 5'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file for the pipelined ARMv8 processor: 32 entries of 64 bits (X0–X31), two combinational read ports, one synchronous write port. It sits between the decode stage, which reads operands, and the write-back stage, which writes results. X31 is the zero register (XZR). Register X20 is exported continuously as a debug/observation port.

## Interface
Parameters: none (width 64 and depth 32 are fixed by the ISA).

Ports:
- `clk`  in  1  system clock; all writes occur on its rising edge
- `Reset`  in  1  asynchronous, active-low reset; clears all registers
- `ReadReg1`  in  5  read port 1 register index
- `ReadReg2`  in  5  read port 2 register index
- `WriteReg`  in  5  write port register index
- `WriteData`  in  64  data to write
- `RegWrite`  in  1  write enable, active high
- `ReadData1`  out  64  contents of register `ReadReg1`
- `ReadData2`  out  64  contents of register `ReadReg2`
- `X20`  out  64  current contents of register 20

## Operation
- Storage: 31 physical 64-bit registers for X0–X30; X31 has no storage.
- Reads: combinational. `ReadDataN` = register[`ReadRegN`]; index 31 returns 64'h0.
- Write: on the rising edge of `clk` with `Reset`=1 and `RegWrite`=1, register[`WriteReg`] <= `WriteData`.
- Writes to index 31 are discarded; XZR always reads zero.
- `RegWrite`=0 leaves all registers unchanged regardless of `WriteReg`/`WriteData`.
- `X20` reflects stored register 20 only (never bypassed, see Configuration).
- Both read ports may address the same register, or the register being written; each port is independent.
- Reset (`Reset`=0): all registers, including X20, clear to 0 immediately, without waiting for a clock edge; writes are blocked while reset is asserted.

## Timing
- Read latency: 0 cycles (combinational from `ReadRegN` and stored state).
- Write latency: the value is visible on read ports and `X20` after the rising edge that samples `RegWrite`=1.
- Reset assertion is asynchronous; deassertion is sampled so that the first write can occur on the first rising edge with `Reset`=1.
- Reset asserted coincident with a write edge: reset wins, register is 0.
- All outputs are 0 during reset, except bypassed read data when `RF_BYPASS_EN` is defined (bypass is suppressed during reset, so also 0).

## Configuration
- `RF_BYPASS_EN`: internal write-to-read forwarding.
- Defined: if `RegWrite`=1, `Reset`=1, `WriteReg`!=31 and `WriteReg`==`ReadRegN`, then `ReadDataN` = `WriteData` combinationally in the same cycle, before the edge. This resolves the write-back/decode hazard without an extra forwarding path.
- Not defined: reads return stored contents only; new data appears after the clock edge.
- Neither mode affects `X20` or index-31 behaviour.

## Test plan
- Reset: hold `Reset`=0, pulse `clk`, set `ReadReg1`=1 and `ReadReg2`=2 -> `ReadData1`=`ReadData2`=`X20`=0.
- Write/read: release reset, `WriteReg`=3, `WriteData`=4, `RegWrite`=1, one rising edge; then `RegWrite`=0, `ReadReg1`=3, `ReadReg2`=2 -> `ReadData1`=4, `ReadData2`=0.
- Zero register: write 64'hDEADBEEF to index 31 -> reading index 31 returns 0 on both ports.
- X20 port: write 64'h0123456789ABCDEF to index 20 -> `X20` equals that value after the edge; a write with `RegWrite`=0 to index 20 leaves it unchanged.
- Bypass: `WriteReg`=5, `WriteData`=9, `RegWrite`=1, `ReadReg1`=5 before the edge -> `ReadData1`=9 when `RF_BYPASS_EN` is defined, or the old value (0) when it is not.
- Asynchronous reset mid-operation: X3=4 stored, drop `Reset` between edges -> `ReadData1` (index 3) becomes 0 immediately.
